// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_skid_reg stage register.
// The optional bubble counter is enabled with the PIPE_BUBBLE_CNT_EN macro.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_CNT_W_DEF = 32;

    // The all-zero payload is the NOP encoding.
    localparam logic PIPE_NOP_BIT = 1'b0;

    function automatic logic is_full(input pipe_state_e st);
        return (st == FULL);
    endfunction

endpackage

// File: rtl/pipe_bubble_cnt.sv
// Saturating up-counter with enable and synchronous clear.
module pipe_bubble_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Count enabled cycles, stick at all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= {W{1'b0}};
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with flush and global pause.
// Define PIPE_BUBBLE_CNT_EN to add the bubble_cnt output.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CNT_W = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam logic [WIDTH-1:0] NOP = {WIDTH{PIPE_NOP_BIT}};

    if ((WIDTH < 1) || (CNT_W < 1)) begin : g_param_chk
        $error("pipe_skid_reg: WIDTH and CNT_W must be >= 1");
    end

    pipe_state_e      state_r, state_s;
    logic [WIDTH-1:0] main_r, main_s;
    logic [WIDTH-1:0] skid_r, skid_s;
    logic             valid_r;
    logic             full_r;
    logic             in_fire_s;
    logic             out_fire_s;

    // full_r mirrors state_r == FULL so in_ready only gates a flop with rdy.
    assign in_ready   = rdy & ~full_r;
    assign out_valid  = valid_r;
    assign out_data   = main_r;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = valid_r & out_ready & rdy;

    // Next-state and storage update: pause beats flush beats normal flow.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (!rdy) begin
            state_s = state_r;
        end else if (flush) begin
            state_s = EMPTY;
            main_s  = NOP;
            skid_s  = NOP;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_s = HALF;
                        main_s  = in_data;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                HALF: begin
                    if (in_fire_s && out_fire_s) begin
                        main_s = in_data;
                    end else if (in_fire_s) begin
                        state_s = FULL;
                        skid_s  = in_data;
                    end else if (out_fire_s) begin
                        // Drained: keep the idle payload at NOP.
                        state_s = EMPTY;
                        main_s  = NOP;
                    end else begin
                        state_s = HALF;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        state_s = HALF;
                        main_s  = skid_r;
                        skid_s  = NOP;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s = EMPTY;
                    main_s  = NOP;
                    skid_s  = NOP;
                end
            endcase
        end
    end

    // State, payload and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            main_r  <= NOP;
            skid_r  <= NOP;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            main_r  <= main_s;
            skid_r  <= skid_s;
            valid_r <= (state_s != EMPTY);
            full_r  <= is_full(state_s);
        end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    pipe_bubble_cnt #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .clr (rst),
        .en  (rdy & ~valid_r),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Generic parametrised pipeline stage register, the successor to the fixed-field per-stage registers (ID/EX style). It carries an opaque WIDTH-bit payload between two pipeline stages with a valid/ready handshake, synchronous flush and global-pause (`rdy`) support. A 2-entry skid buffer registers both `in_ready` and `out_valid`, so there is no combinational path from `out_ready` to `in_ready`. The controller drives `flush` in place of the old stall-vector bubble insertion.

## Interface
- WIDTH, 128: payload width in bits (≥1)
- CNT_W, 32: bubble-counter width (used only with PIPE_BUBBLE_CNT_EN)

Ports:
- clk  in  1  rising-edge clock, the single clock domain
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; 0 freezes the block
- flush  in  1  discard all held beats (branch mispredict / exception)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat; registered state gated by `rdy`
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  `out_data` valid (registered)
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload (registered)
- bubble_cnt  out  CNT_W  cycles with `out_valid`=0; present only with the macro

## Operation
- Handshake signals:
  - in_fire = `in_valid & in_ready`
  - out_fire = `out_valid & out_ready & rdy`
  - `in_ready` = `rdy & (state != FULL)`
- Storage: `main` register drives `out_data`; `skid` holds one overflow beat.
- States:
  - EMPTY: in_fire → HALF, main<=in_data.
  - HALF:
    - in_fire & out_fire → HALF, main<=in_data.
    - in_fire & !out_fire → FULL, skid<=in_data.
    - !in_fire & out_fire → EMPTY.
    - Neither → hold.
  - FULL: out_fire → HALF, main<=skid. No in_fire is possible.
- `out_valid` = (state != EMPTY).
- Priority, highest first:
  1. rst: state EMPTY, main and skid zeroed.
  2. !rdy: everything holds, including the counter; `flush` is ignored.
  3. flush: state EMPTY, main and skid zeroed; a simultaneous in_fire beat is dropped.
  4. Normal transitions.
- Controller holds `flush` high until it is sampled with `rdy`=1.
- Zeroed payload is the all-zero NOP encoding. Downstream must not rely on `out_data` when `out_valid`=0, but the value is zero.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush or rst.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=`rdy`, `bubble_cnt`=0.
- Latency: a beat accepted at edge N appears on `out_data`/`out_valid` after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Backpressure: after `out_ready` drops, at most one more beat is accepted (into skid), and `in_ready` falls the following cycle.
- Flush takes effect at the edge where it is sampled: `out_valid`=0 from the next cycle, and `in_ready` is 1 next cycle if `rdy`.
- rst or flush asserted mid-FULL discards both beats.

## Configuration
- PIPE_BUBBLE_CNT_EN defined:
  - `bubble_cnt` port exists.
  - Increments by 1 every cycle with `rdy`=1, rst=0 and `out_valid`=0.
  - Saturates at all-ones. Cleared only by rst, not by flush.
- PIPE_BUBBLE_CNT_EN undefined: port and counter logic absent; behaviour is otherwise identical.

## Structure
- Package `pipe_pkg`:
  - state enum (EMPTY, HALF, FULL, 2 bits)
  - zero/NOP payload constant helper
  - default CNT_W
- One sub-module, `pipe_bubble_cnt`: saturating counter with enable and sync clear, instantiated only under PIPE_BUBBLE_CNT_EN.

## Test plan
- Stream: 8 beats 0x1..0x8 with `in_valid`=1 and `out_ready`=1 → out 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance; `in_ready` stays 1.
- Backpressure: load 0xA, then drop `out_ready` while offering 0xB, 0xC → 0xB goes to skid, `in_ready`=0 next cycle, 0xC is held upstream. Raise `out_ready` → output order 0xA, 0xB, 0xC with no loss.
- Flush in FULL (0xA in main, 0xB in skid) with `in_valid`=1, data 0xD → next cycle `out_valid`=0, `out_data`=0, and 0xD is dropped.
- `rdy`=0 for 3 cycles in HALF with `flush`=1 and `out_ready`=1 → state, `out_data` and counter unchanged, and `in_ready`=0. When `rdy` returns with flush still high → flushed.
- rst asserted mid-stream while FULL → next cycle `out_valid`=0, `out_data`=0, `in_ready`=1, `bubble_cnt`=0.
- Macro on, CNT_W=4, 20 idle cycles → `bubble_cnt` saturates at 15. Flush does not clear it.
